rsa_exp_ctrl: RTL and testbench

- Sequences a Montgomery modular-multiplier datapath to compute c = m^e mod p by left-to-right square-and-multiply.
- Sits between the SPI register bank (start/stop pulses, p/e/m/const operands; const = R^2 mod p, R = 2^WIDTH) and a shared multiplier instance that computes a·b·R^-1 mod p.
- Reports the ciphertext and a one-cycle eoc pulse, which the register bank captures into its C register.

---
 rtl/rsa_pkg.sv | 27 ++
 rtl/rsa_exp_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_rsa_exp_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared types for the RSA exponentiation controller.
//   rsa_state_e : controller FSM states
//   rsa_op_e    : operand pairing presented to the Montgomery multiplier
//   RSA_WIDTH   : default operand / exponent width
package rsa_pkg;

  localparam int RSA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    PRE_M,
    PRE_X,
    SQR,
    MUL,
    POST,
    DONE
  } rsa_state_e;

  typedef enum logic [2:0] {
    OP_M_CONST,
    OP_ONE_CONST,
    OP_X_X,
    OP_X_MBAR,
    OP_X_ONE
  } rsa_op_e;

endpackage

// File: rtl/rsa_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for a shared Montgomery
// multiplier (MM(a,b) = a*b*R^-1 mod p, R = 2^WIDTH). Computes
// rsa_c = rsa_m^rsa_e mod rsa_p.
//
// Ports
//   clk, rstb             clock, async active-low reset
//   ena                   global enable; everything holds while low
//   start_cmd, stop_cmd   one-cycle command pulses
//   rsa_p/e/m/const       operands (const = R^2 mod p), latched on start
//   mm_start, mm_a, mm_b  multiplication launch and operands
//   mm_p                  latched modulus
//   mm_abort              cancels an in-flight multiplication
//   mm_done, mm_result    multiplier completion and result
//   rsa_c, eoc, busy      result, end-of-computation pulse, busy flag
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for start_cmd
// PRE_M | mbar = MM(m, const), m into Montgomery domain
// PRE_X | x = MM(1, const) = R mod p
// SQR   | x = MM(x, x) for exponent bit k
// MUL   | x = MM(x, mbar) when e[k] = 1
// POST  | c = MM(x, 1), back out of Montgomery domain
// DONE  | eoc cycle, return to IDLE
module rsa_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             start_cmd,
  input  logic             stop_cmd,
  input  logic [WIDTH-1:0] rsa_p,
  input  logic [WIDTH-1:0] rsa_e,
  input  logic [WIDTH-1:0] rsa_m,
  input  logic [WIDTH-1:0] rsa_const,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  output logic [WIDTH-1:0] mm_p,
  output logic             mm_abort,
  input  logic             mm_done,
  input  logic [WIDTH-1:0] mm_result,
  output logic [WIDTH-1:0] rsa_c,
  output logic             eoc,
  output logic             busy
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [KW-1:0] K_TOP = KW'(WIDTH - 1);

  rsa_state_e state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] const_q, const_d;
  logic [WIDTH-1:0] mbar_q, mbar_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] mm_a_q, mm_a_d;
  logic [WIDTH-1:0] mm_b_q, mm_b_d;
  logic [WIDTH-1:0] rsa_c_q, rsa_c_d;
  logic mm_start_q, mm_start_d;
  logic mm_abort_q, mm_abort_d;
  logic eoc_q, eoc_d;
  logic busy_q, busy_d;

  logic launch;
  logic step_next;
  rsa_op_e op_sel;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= IDLE;
      k_q        <= '0;
      p_q        <= '0;
      e_q        <= '0;
      m_q        <= '0;
      const_q    <= '0;
      mbar_q     <= '0;
      x_q        <= '0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      rsa_c_q    <= '0;
      mm_start_q <= 1'b0;
      mm_abort_q <= 1'b0;
      eoc_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      p_q        <= p_d;
      e_q        <= e_d;
      m_q        <= m_d;
      const_q    <= const_d;
      mbar_q     <= mbar_d;
      x_q        <= x_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
      rsa_c_q    <= rsa_c_d;
      mm_start_q <= mm_start_d;
      mm_abort_q <= mm_abort_d;
      eoc_q      <= eoc_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    p_d        = p_q;
    e_d        = e_q;
    m_d        = m_q;
    const_d    = const_q;
    mbar_d     = mbar_q;
    x_d        = x_q;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;
    rsa_c_d    = rsa_c_q;
    mm_start_d = mm_start_q;
    mm_abort_d = mm_abort_q;
    eoc_d      = eoc_q;
    busy_d     = busy_q;
    launch     = 1'b0;
    step_next  = 1'b0;
    op_sel     = OP_X_X;

    // With ena low nothing moves, pulses included.
    if (ena) begin
      mm_start_d = 1'b0;
      mm_abort_d = 1'b0;
      eoc_d      = 1'b0;

      case (state_q)
        IDLE: begin
          if (start_cmd && !stop_cmd) begin
            p_d     = rsa_p;
            e_d     = rsa_e;
            m_d     = rsa_m;
            const_d = rsa_const;
            busy_d  = 1'b1;
            state_d = PRE_M;
            launch  = 1'b1;
            op_sel  = OP_M_CONST;
          end
        end

        DONE: state_d = IDLE;

        default: begin
          if (stop_cmd) begin
            // Abort even if mm_done coincides: the result is discarded and
            // an abort to an idle multiplier is harmless.
            state_d    = IDLE;
            busy_d     = 1'b0;
            mm_abort_d = 1'b1;
          end else if (mm_done) begin
            case (state_q)
              PRE_M: begin
                mbar_d  = mm_result;
                state_d = PRE_X;
                launch  = 1'b1;
                op_sel  = OP_ONE_CONST;
              end
              PRE_X: begin
                x_d     = mm_result;
                k_d     = K_TOP;
                state_d = SQR;
                launch  = 1'b1;
                op_sel  = OP_X_X;
              end
              SQR: begin
                x_d = mm_result;
                if (e_q[k_q]) begin
                  state_d = MUL;
                  launch  = 1'b1;
                  op_sel  = OP_X_MBAR;
                end else begin
                  step_next = 1'b1;
                end
              end
              MUL: begin
                x_d       = mm_result;
                step_next = 1'b1;
              end
              POST: begin
                rsa_c_d = mm_result;
                eoc_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
              end
              default: ;
            endcase
          end
        end
      endcase

      // Zero-cycle NEXT step: move to the next exponent bit or finish.
      if (step_next) begin
        launch = 1'b1;
        if (k_q == '0) begin
          state_d = POST;
          op_sel  = OP_X_ONE;
        end else begin
          k_d     = k_q - 1'b1;
          state_d = SQR;
          op_sel  = OP_X_X;
        end
      end

      // Operands come from the _d values so a freshly captured x is used.
      if (launch) begin
        mm_start_d = 1'b1;
        case (op_sel)
          OP_M_CONST:   begin mm_a_d = m_d; mm_b_d = const_d; end
          OP_ONE_CONST: begin mm_a_d = ONE; mm_b_d = const_d; end
          OP_X_X:       begin mm_a_d = x_d; mm_b_d = x_d;     end
          OP_X_MBAR:    begin mm_a_d = x_d; mm_b_d = mbar_d;  end
          OP_X_ONE:     begin mm_a_d = x_d; mm_b_d = ONE;     end
          default:      begin mm_a_d = x_d; mm_b_d = x_d;     end
        endcase
      end
    end
  end

  assign mm_start = mm_start_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign mm_p     = p_q;
  assign mm_abort = mm_abort_q;
  assign rsa_c    = rsa_c_q;
  assign eoc      = eoc_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
module tb_rsa_exp_ctrl;

  localparam int W = 8;
  localparam int L = 3;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic         ena = 1'b1;
  logic         start_cmd = 1'b0;
  logic         stop_cmd = 1'b0;
  logic [W-1:0] rsa_p = '0;
  logic [W-1:0] rsa_e = '0;
  logic [W-1:0] rsa_m = '0;
  logic [W-1:0] rsa_const = '0;
  logic         mm_start;
  logic [W-1:0] mm_a;
  logic [W-1:0] mm_b;
  logic [W-1:0] mm_p;
  logic         mm_abort;
  logic         mm_done = 1'b0;
  logic [W-1:0] mm_result = '0;
  logic [W-1:0] rsa_c;
  logic         eoc;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  rsa_exp_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rstb(rstb), .ena(ena),
    .start_cmd(start_cmd), .stop_cmd(stop_cmd),
    .rsa_p(rsa_p), .rsa_e(rsa_e), .rsa_m(rsa_m), .rsa_const(rsa_const),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_p(mm_p),
    .mm_abort(mm_abort), .mm_done(mm_done), .mm_result(mm_result),
    .rsa_c(rsa_c), .eoc(eoc), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Montgomery product a*b*R^-1 mod p, with R^-1 found by search.
  function automatic int mont(input int a, input int b, input int p);
    int rinv;
    rinv = 0;
    for (int r = 1; r < p; r++)
      if (((1 << W) * r) % p == 1) rinv = r;
    return (((a * b) % p) * rinv) % p;
  endfunction

  function automatic int modexp(input int m, input int e, input int p);
    int c;
    c = 1 % p;
    for (int i = 0; i < e; i++) c = (c * m) % p;
    return c;
  endfunction

  // Multiplier model: latency L, gated by ena, ignores mm_abort so that a
  // late completion reaches the controller after a stop.
  int mm_cnt = 0;
  int mm_res = 0;
  always @(negedge clk) begin
    #1;
    if (ena) begin
      mm_done = 1'b0;
      if (mm_cnt > 0) begin
        mm_cnt--;
        if (mm_cnt == 0) begin
          mm_done   = 1'b1;
          mm_result = W'(mm_res);
        end
      end
      if (mm_start) begin
        mm_res = mont(int'(mm_a), int'(mm_b), int'(mm_p));
        mm_cnt = L;
      end
    end
  end

  task automatic run(input string tag, input int p, input int e, input int m,
                     input int stop_at, input int restart_at,
                     input int ena_from, input int ena_to,
                     input int rst_at, input int prev_c);
    int t0, limit, eoc_rel, n_eoc, n_mm, first_mm, abort_rel, exp_eoc, n_ops;
    repeat (6) @(negedge clk);
    rsa_p = W'(p);
    rsa_e = W'(e);
    rsa_m = W'(m);
    rsa_const = W'(((1 << W) * (1 << W)) % p);
    start_cmd = 1'b1;
    ena = 1'b1;
    t0 = cyc;
    eoc_rel = -1; n_eoc = 0; n_mm = 0; first_mm = -1; abort_rel = -1;
    n_ops = 3 + W + $countones(W'(e));
    exp_eoc = 1 + n_ops * (L + 1);
    if (ena_from >= 0) exp_eoc += ena_to - ena_from + 1;
    limit = (stop_at >= 0) ? stop_at + 30 : (rst_at >= 0) ? rst_at + 30 : exp_eoc + 40;
    for (int t = 1; t <= limit; t++) begin
      @(negedge clk);
      start_cmd = 1'b0;
      stop_cmd = 1'b0;
      ena = 1'b1;
      if (t == stop_at) begin stop_cmd = 1'b1; start_cmd = 1'b1; end
      if (t == restart_at) begin start_cmd = 1'b1; rsa_m = 8'd7; end
      if (ena_from >= 0 && t >= ena_from && t <= ena_to) ena = 1'b0;
      if (t == rst_at) rstb = 1'b0;
      if (t == rst_at + 1) rstb = 1'b1;
      #1;
      if (ena && mm_start) begin
        n_mm++;
        if (first_mm < 0) first_mm = t;
      end
      if (mm_abort && abort_rel < 0) abort_rel = t;
      if (eoc && ena) begin
        n_eoc++;
        if (eoc_rel < 0) begin
          eoc_rel = t;
          chk({tag, "_busy_at_eoc"}, int'(busy), 0);
        end
      end
      if (t == 1) chk({tag, "_busy_c1"}, int'(busy), 1);
      if (t == stop_at + 1) chk({tag, "_busy_after_stop"}, int'(busy), 0);
      if (t == rst_at) begin
        chk({tag, "_rst_busy"}, int'(busy), 0);
        chk({tag, "_rst_mm_start"}, int'(mm_start), 0);
        chk({tag, "_rst_ab_p"}, int'({mm_a, mm_b, mm_p}), 0);
        chk({tag, "_rst_c_eoc_abort"}, int'({rsa_c, eoc, mm_abort}), 0);
      end
      if (eoc_rel >= 0 && t >= eoc_rel + 3) break;
    end
    if (stop_at < 0 && rst_at < 0) begin
      chk({tag, "_eoc_cycle"}, eoc_rel, exp_eoc);
      chk({tag, "_rsa_c"}, int'(rsa_c), modexp(m, e, p));
      chk({tag, "_n_ops"}, n_mm, n_ops);
      chk({tag, "_first_mm"}, first_mm, 1);
      chk({tag, "_n_eoc"}, n_eoc, 1);
      chk({tag, "_mm_p"}, int'(mm_p), p);
    end else begin
      chk({tag, "_no_eoc"}, n_eoc, 0);
      chk({tag, "_rsa_c_kept"}, int'(rsa_c), prev_c);
      if (stop_at >= 0) chk({tag, "_abort_cycle"}, abort_rel, stop_at + 1);
    end
  endtask

  initial begin
    int p, e, m;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_eoc", int'(eoc), 0);
    chk("reset_rsa_c", int'(rsa_c), 0);
    chk("reset_mm", int'({mm_start, mm_abort, mm_a, mm_b, mm_p}), 0);
    rstb = 1'b1;

    run("t2", 13, 5, 4, -1, -1, -1, -1, -1, 0);
    run("t3a", 13, 2, 12, -1, -1, -1, -1, -1, 0);
    run("t3b", 11, 0, 3, -1, -1, -1, -1, -1, 0);
    run("t2b", 13, 5, 4, -1, -1, -1, -1, -1, 0);
    run("stop20", 13, 5, 4, 20, -1, -1, -1, -1, 10);
    run("after_stop", 11, 7, 3, -1, -1, -1, -1, -1, 0);
    run("stop22", 13, 5, 4, 22, -1, -1, -1, -1, 3 ** 7 % 11);
    run("restart", 13, 5, 4, -1, 10, -1, -1, -1, 0);
    run("ena_gap", 13, 5, 4, -1, -1, 15, 24, -1, 0);
    run("rst30", 13, 5, 4, -1, -1, -1, -1, 30, 0);
    run("m_zero", 13, 9, 0, -1, -1, -1, -1, -1, 0);
    run("e_full", 251, 255, 250, -1, -1, -1, -1, -1, 0);

    for (int i = 0; i < 8; i++) begin
      p = 2 * $urandom_range(1, 127) + 1;
      m = $urandom_range(0, p - 1);
      e = $urandom_range(0, 255);
      run("rand", p, e, m, -1, -1, -1, -1, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
